// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 5-stage RV64 pipeline.
//
// Generates the PC, issues one instruction-bus request at a time
// (req/data_ok handshake, zero-wait responses allowed), and hands
// {valid, pc, raw_instr} to decode.
// Redirects that arrive while a fetch is in flight park the target
// until the in-flight response has been dropped.
// A one-entry skid buffer absorbs the response that lands while decode
// is stalled.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   branch, jump      redirect pulse and its 64-bit target
//   stall             decode cannot accept; f_* hold
//   ireq_valid/addr   instruction request (held until iresp_data_ok)
//   iresp_data_ok     completes the outstanding request
//   iresp_data        instruction word
//   f_valid/pc/raw_instr  fetched entry to decode
//   f_misalign        only with FETCH_ALIGN_CHECK_EN
//
// Build option:
//   FETCH_ALIGN_CHECK_EN  When defined, a misaligned fetch address is not
//                         sent to the bus. Instead, a nop entry flagged
//                         f_misalign is delivered. Issue then halts until
//                         the next branch.
//
// States:
//   ISSUE   | normal fetch; request pc_q whenever the skid is empty
//   DISCARD | redirect taken mid-request; hold request, drop its response
module fetch_unit #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch,
  input  logic [63:0] jump,
  input  logic        stall,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_raw_instr
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        f_misalign
`endif
);

  typedef enum logic {ISSUE, DISCARD} state_t;

  state_t      state_q;
  logic        run_q;       // low for the first cycle out of reset
  logic [63:0] pc_q;
  logic [63:0] target_q;
  logic        skid_valid;
  logic [63:0] skid_pc;
  logic [31:0] skid_instr;

  logic        halt;
  logic        misalign_hit;
  logic        resp;
  logic        consume;
  logic        slot_free;

`ifdef FETCH_ALIGN_CHECK_EN
  logic halt_q;
  assign halt         = halt_q;
  assign misalign_hit = (pc_q[1:0] != 2'b00);
`else
  assign halt         = 1'b0;
  assign misalign_hit = 1'b0;
`endif

  // pc_q only moves when no request is in flight, so the address is stable
  // for the whole life of a request (DISCARD keeps the old pc_q too).
  assign ireq_addr  = pc_q;
  assign ireq_valid = run_q &&
                      ((state_q == DISCARD) ||
                       (!skid_valid && !halt && !misalign_hit));

  assign resp      = ireq_valid && iresp_data_ok;
  assign consume   = f_valid && !stall;
  assign slot_free = !f_valid || consume;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ISSUE;
      run_q       <= 1'b0;
      pc_q        <= PC_RESET;
      target_q    <= '0;
      skid_valid  <= 1'b0;
      skid_pc     <= '0;
      skid_instr  <= '0;
      f_valid     <= 1'b0;
      f_pc        <= '0;
      f_raw_instr <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      halt_q      <= 1'b0;
      f_misalign  <= 1'b0;
`endif
    end else begin
      run_q <= 1'b1;
      if (consume) f_valid <= 1'b0;

      if (branch) begin
        // Redirect wins over stall: everything already fetched is stale.
        f_valid    <= 1'b0;
        skid_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        halt_q     <= 1'b0;
        f_misalign <= 1'b0;
`endif
        if (ireq_valid && !iresp_data_ok) begin
          target_q <= jump;
          state_q  <= DISCARD;
        end else begin
          pc_q    <= jump;
          state_q <= ISSUE;
        end
      end else begin
        case (state_q)
          ISSUE: begin
            if (skid_valid && consume) begin
              f_valid     <= 1'b1;
              f_pc        <= skid_pc;
              f_raw_instr <= skid_instr;
              skid_valid  <= 1'b0;
            end
            // The skid is empty whenever a response can arrive (full skid
            // blocks issue), so the two branches below never collide with
            // the drain above.
            if (resp) begin
              pc_q <= pc_q + 64'd4;
              if (slot_free) begin
                f_valid     <= 1'b1;
                f_pc        <= pc_q;
                f_raw_instr <= iresp_data;
              end else begin
                skid_valid <= 1'b1;
                skid_pc    <= pc_q;
                skid_instr <= iresp_data;
              end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            if (misalign_hit && !halt_q && !skid_valid && slot_free) begin
              f_valid     <= 1'b1;
              f_misalign  <= 1'b1;
              f_pc        <= pc_q;
              f_raw_instr <= 32'h0000_0013;
              halt_q      <= 1'b1;
            end
`endif
          end
          DISCARD: begin
            if (iresp_data_ok) begin
              pc_q    <= target_q;
              state_q <= ISSUE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch = 1'b0;
  logic [63:0] jump = '0;
  logic        stall = 1'b0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_raw_instr;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        f_misalign;
`endif

  fetch_unit #(.PC_RESET(PC_RESET)) dut (
    .clk           (clk),
    .reset         (reset),
    .branch        (branch),
    .jump          (jump),
    .stall         (stall),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .f_valid       (f_valid),
    .f_pc          (f_pc),
    .f_raw_instr   (f_raw_instr)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .f_misalign    (f_misalign)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- instruction memory / bus model ----------------
  int lat_cfg  = 1;   // cycles a request is visible before data_ok; 0 = random 1..4
  bit nop_mode = 1'b1;
  int age      = 0;
  int cur_lat  = 1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return nop_mode ? 32'h0000_0013 : (a[31:0] ^ 32'h5A5A_0003);
  endfunction

  function automatic logic [31:0] exp_word(input logic [63:0] a);
    return (a[1:0] != 2'b00) ? 32'h0000_0013 : mem_word(a);
  endfunction

  always @(negedge clk) begin
    if (reset || !ireq_valid) begin
      iresp_data_ok = 1'b0;
      age = 0;
    end else begin
      if (age == 0) cur_lat = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
      age++;
      if (age >= cur_lat) begin
        iresp_data_ok = 1'b1;
        iresp_data    = mem_word(ireq_addr);
        age = 0;
      end else begin
        iresp_data_ok = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Two pointers: exp_pc is the next PC decode should see, next_req the
  // next address the bus should see. A request the bus has not completed
  // is "held"; a redirect during a held request marks its response dropped.
  logic [63:0] exp_pc      = PC_RESET;
  logic [63:0] next_req    = PC_RESET;
  logic [63:0] held_addr   = '0;
  logic [63:0] mdl_addr;
  bit          held        = 1'b0;
  bit          drop        = 1'b0;
  bit          prev_reset  = 1'b1;
  bit          hold_pending = 1'b0;
  int          delivered   = 0;

  always begin
    @(negedge clk);
    #1;
    if (prev_reset) begin
      check_eq("rst_f_valid", f_valid, 1'b0);
      check_eq("rst_ireq_valid", ireq_valid, 1'b0);
      check_eq("rst_f_pc", f_pc, 64'h0);
      check_eq("rst_f_raw_instr", f_raw_instr, 32'h0);
    end else begin
      if (hold_pending) check_eq("stall_hold_valid", f_valid, 1'b1);
      if (f_valid) begin
        check_eq("f_pc", f_pc, exp_pc);
        check_eq("f_raw_instr", f_raw_instr, exp_word(exp_pc));
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("f_misalign", f_misalign, exp_pc[1:0] != 2'b00);
`endif
      end
      if (held) check_eq("req_held", ireq_valid, 1'b1);
      if (ireq_valid) check_eq("ireq_addr", ireq_addr, held ? held_addr : next_req);
`ifdef FETCH_ALIGN_CHECK_EN
      if (!held && next_req[1:0] != 2'b00) check_eq("misalign_noreq", ireq_valid, 1'b0);
`endif
    end

    if (reset) begin
      exp_pc       = PC_RESET;
      next_req     = PC_RESET;
      held         = 1'b0;
      drop         = 1'b0;
      hold_pending = 1'b0;
    end else begin
      hold_pending = f_valid && stall && !branch;
      if (f_valid && !stall) begin
        exp_pc = exp_pc + 64'd4;
        delivered++;
      end
      if (ireq_valid) begin
        mdl_addr = held ? held_addr : next_req;
        if (iresp_data_ok) begin
          if (!drop && !branch) next_req = mdl_addr + 64'd4;
          held = 1'b0;
          drop = 1'b0;
        end else begin
          held      = 1'b1;
          held_addr = mdl_addr;
          if (branch) drop = 1'b1;
        end
      end
      if (branch) begin
        exp_pc   = jump;
        next_req = jump;
      end
    end
    prev_reset = reset;
  end

  // ---------------- stimulus ----------------
  // Inputs change 1 ns after the rising edge; observations are taken
  // 2 ns after the falling edge.
  task automatic cyc(input logic br, input logic [63:0] jmp, input logic st, input logic rs);
    @(posedge clk);
    #1;
    branch = br;
    jump   = jmp;
    stall  = st;
    reset  = rs;
    @(negedge clk);
    #2;
  endtask

  // Returns observing cycle 0 (reset just released, nothing issued yet).
  task automatic do_reset(input int lat, input bit nop);
    cyc(1'b0, 64'h0, 1'b0, 1'b1);
    cyc(1'b0, 64'h0, 1'b0, 1'b1);
    lat_cfg  = lat;
    nop_mode = nop;
    cyc(1'b0, 64'h0, 1'b0, 1'b1);
    cyc(1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  int cnt_v;
  int cnt_a;
  int cnt_bad;
  int start_del;
  logic [63:0] rj;

  initial begin
    // Zero-wait bus returning nops: back-to-back delivery.
    do_reset(1, 1'b1);
    check_eq("c0_ireq_valid", ireq_valid, 1'b0);
    cyc(1'b0, 64'h0, 1'b0, 1'b0);
    check_eq("c1_ireq_valid", ireq_valid, 1'b1);
    check_eq("c1_ireq_addr", ireq_addr, 64'h8000_0000);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 64'h0, 1'b0, 1'b0);
      check_eq("tput_f_valid", f_valid, 1'b1);
      check_eq("tput_f_pc", f_pc, 64'h8000_0000 + 64'(4 * k));
      check_eq("tput_f_raw", f_raw_instr, 32'h0000_0013);
    end

    // 3-cycle bus latency.
    do_reset(3, 1'b0);
    cnt_v = 0;
    cnt_a = 0;
    for (int c = 1; c <= 12; c++) begin
      cyc(1'b0, 64'h0, 1'b0, 1'b0);
      if (f_valid) cnt_v++;
      if (ireq_valid && ireq_addr == 64'h8000_0000) cnt_a++;
      if (c == 4) begin
        check_eq("lat3_first_valid", f_valid, 1'b1);
        check_eq("lat3_first_pc", f_pc, 64'h8000_0000);
      end
    end
    check_eq("lat3_valid_pulses", cnt_v, 3);
    check_eq("lat3_addr_cycles", cnt_a, 3);

    // Redirect during an outstanding request: DISCARD until data_ok.
    do_reset(3, 1'b0);
    cnt_bad = 0;
    for (int c = 1; c <= 16; c++) begin
      cyc(c == 8, 64'h8000_1000, 1'b0, 1'b0);
      if (f_valid && f_pc == 64'h8000_0008) cnt_bad++;
      if (c == 8) check_eq("disc_addr_c8", ireq_addr, 64'h8000_0008);
      if (c == 9) begin
        check_eq("disc_hold_valid", ireq_valid, 1'b1);
        check_eq("disc_hold_addr", ireq_addr, 64'h8000_0008);
        check_eq("disc_f_valid", f_valid, 1'b0);
      end
      if (c == 10) begin
        check_eq("disc_new_valid", ireq_valid, 1'b1);
        check_eq("disc_new_addr", ireq_addr, 64'h8000_1000);
      end
      if (c == 13) begin
        check_eq("disc_deliver_valid", f_valid, 1'b1);
        check_eq("disc_deliver_pc", f_pc, 64'h8000_1000);
      end
    end
    check_eq("disc_dropped_never_seen", cnt_bad, 0);

    // Redirect on the same cycle as data_ok.
    do_reset(3, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      cyc(c == 3, 64'h8000_2000, 1'b0, 1'b0);
      if (c == 4) begin
        check_eq("same_cyc_valid", ireq_valid, 1'b1);
        check_eq("same_cyc_addr", ireq_addr, 64'h8000_2000);
        check_eq("same_cyc_f_valid", f_valid, 1'b0);
      end
      if (c == 7) check_eq("same_cyc_deliver_pc", f_pc, 64'h8000_2000);
    end

    // Stall for 4 cycles on a zero-wait bus: skid captures one word.
    do_reset(1, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      cyc(1'b0, 64'h0, (c >= 3 && c <= 6), 1'b0);
      if (c >= 3 && c <= 7) begin
        check_eq("stall_f_valid", f_valid, 1'b1);
        check_eq("stall_f_pc", f_pc, 64'h8000_0004);
      end
      if (c >= 4 && c <= 7) check_eq("stall_no_issue", ireq_valid, 1'b0);
      if (c == 8) begin
        check_eq("skid_out_pc", f_pc, 64'h8000_0008);
        check_eq("resume_addr", ireq_addr, 64'h8000_000C);
        check_eq("resume_valid", ireq_valid, 1'b1);
      end
      if (c == 9) check_eq("after_skid_pc", f_pc, 64'h8000_000C);
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect target.
    do_reset(1, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      cyc(c == 3 || c == 8, (c == 3) ? 64'h8000_0002 : 64'h8000_0100, 1'b0, 1'b0);
      if (c == 4 || c == 6 || c == 7) check_eq("mis_no_req", ireq_valid, 1'b0);
      if (c == 5) begin
        check_eq("mis_f_valid", f_valid, 1'b1);
        check_eq("mis_flag", f_misalign, 1'b1);
        check_eq("mis_f_pc", f_pc, 64'h8000_0002);
        check_eq("mis_f_raw", f_raw_instr, 32'h0000_0013);
      end
      if (c == 9) begin
        check_eq("mis_resume_valid", ireq_valid, 1'b1);
        check_eq("mis_resume_addr", ireq_addr, 64'h8000_0100);
        check_eq("mis_flag_clear", f_misalign, 1'b0);
      end
    end
`endif

    // Randomized traffic against the model.
    do_reset(0, 1'b0);
    start_del = delivered;
    for (int i = 0; i < 3000; i++) begin
      rj = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 19) == 0) rj = 64'hFFFF_FFFF_FFFF_FFF8;
`ifdef FETCH_ALIGN_CHECK_EN
      if ($urandom_range(0, 9) == 0) rj[1:0] = 2'($urandom_range(1, 3));
`endif
      cyc($urandom_range(0, 99) < 7, rj, $urandom_range(0, 99) < 30,
          $urandom_range(0, 299) == 0);
    end
    cyc(1'b0, 64'h0, 1'b0, 1'b0);
    check_eq("random_progress", (delivered - start_del) > 100, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RV64 pipeline. Consumes the execute stage's redirect pair (branch, jump) and generates the PC.
- Issues requests on the instruction bus with a req/data_ok handshake. Delivers {valid, pc, raw_instr} to decode.
- Handles redirects that arrive while a fetch is outstanding, and downstream stall, using a one-entry skid buffer.

Parameters:
- PC_RESET, 64'h0000_0000_8000_0000, PC of the first fetch after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- branch  in  1  redirect request from execute; one-cycle pulse per redirect.
- jump  in  64  redirect target; valid when branch=1.
- stall  in  1  decode cannot accept; dataF holds.
- ireq_valid  out  1  instruction request valid.
- ireq_addr  out  64  instruction request address.
- iresp_data_ok  in  1  response valid; completes the outstanding request.
- iresp_data  in  32  instruction word.
- f_valid  out  1  fetched instruction valid to decode.
- f_pc  out  64  PC of the fetched instruction.
- f_raw_instr  out  32  fetched instruction word.

Behaviour:
Reset:
- f_valid=0, f_pc=0, f_raw_instr=0, ireq_valid=0.
- pc_q=PC_RESET, skid empty, state=ISSUE.
- Reset asserted mid-transaction returns to these values and ignores any later data_ok for the abandoned request.

Bus protocol:
- Once ireq_valid=1, ireq_addr stays stable and ireq_valid stays high until the cycle iresp_data_ok=1.
- One request is outstanding at most. Zero-wait data_ok (same cycle as ireq_valid) is legal.

Downstream handshake:
- An entry is consumed on a cycle with f_valid=1 and stall=0.
- While stall=1, f_* hold their values.

States:
- ISSUE:
  - ireq_valid=1, ireq_addr=pc_q, when the skid is empty.
  - Otherwise ireq_valid=0.
  - data_ok with no branch: stay in ISSUE and accept the response (see Response routing).
  - data_ok with branch: see Redirect.
- DISCARD:
  - Entered on branch without data_ok while a request is outstanding.
  - ireq_valid=1 and the old address are held until data_ok.
  - The response is dropped.
  - Next state is ISSUE with pc_q=saved target.

Response routing (accepted response in ISSUE):
- If f_valid=0 or the entry is consumed this cycle: the response loads f_* next cycle.
- Otherwise: the response goes to the skid.
- pc_q advances by 4 (64-bit wrap).

Skid:
- When the skid is full and the f_* entry is consumed, the skid moves into f_* next cycle.
- The next request issues the cycle after the skid empties.
- Skid full blocks issue. Throughput is 1 instruction per cycle with a zero-wait bus.

Redirect (branch=1; applies regardless of stall and takes priority over it):
- Next cycle f_valid=0 and the skid is cleared.
- If no request is outstanding, or data_ok arrives in the same cycle (the response is dropped): pc_q=jump, state ISSUE, and the next request uses jump.
- Otherwise: the target is saved and the state goes to DISCARD.
- A second branch while in DISCARD overwrites the saved target.
- An instruction arriving on the same cycle as branch is never delivered.

Arithmetic:
- All PC arithmetic is 64-bit unsigned.
- jump bits [1:0] are passed through unmodified.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- When defined:
  - Adds output port f_misalign (1).
  - If the address about to be issued has bits [1:0] != 0, no bus request is made.
  - Instead f_valid=1, f_misalign=1, f_pc=that address, f_raw_instr=32'h0000_0013 (nop).
  - The unit then halts issue until the next branch or reset.
  - f_misalign resets to 0 and clears on branch.
- When undefined: the port is absent and the address is issued unchecked.

Test Plan:
- Reset, zero-wait bus returning 32'h00000013 → first ireq_addr=0x8000_0000 one cycle after reset deasserts. f_pc sequence 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, f_valid=1.
- Bus with 3-cycle latency → ireq_addr stays 0x80000000 for 3 cycles. f_valid pulses once per 3 cycles with correct f_pc.
- branch=1, jump=0x80001000 two cycles into a 3-cycle outstanding request at 0x80000008 → stays in DISCARD until data_ok. 0x80000008 is never delivered. The next ireq_addr is 0x80001000.
- branch with jump=0x80002000 on the same cycle as data_ok → that response is dropped. The next ireq_addr is 0x80002000 on the following cycle.
- stall=1 for 4 cycles with zero-wait bus → f_* hold. The skid captures one word and issue stops. After stall drops, the skid entry is delivered and no PC is lost or duplicated.
- With FETCH_ALIGN_CHECK_EN: branch to 0x80000002 → no request, f_misalign=1, f_pc=0x80000002. A following branch to 0x80000100 resumes fetch.
